mips_trace_capture: RTL and testbench
=====================================

Name: mips_trace_capture

Overview:
- Passive observer that sits on the processor's pc_out/alu_result outputs, opposite the processor end of that interface.
- Records each retired-PC change as a time-stamped trace entry in an internal FIFO.
- Entries drain through a valid/ready read port, so a bench, debug UART or logger can consume them at its own pace.
- Replaces free-running $display monitoring with a synthesizable, back-pressured trace stream.

Parameters:
- PC_WIDTH, 16, width of observed program counter
- DATA_WIDTH, 16, width of observed ALU result
- TS_WIDTH, 16, width of free-running cycle timestamp
- DEPTH, 8, FIFO entries; power of two, >= 2
- CNT_WIDTH, 8, width of saturating drop counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- trace_en  input  1  capture enable
- pc_in  input  PC_WIDTH  processor pc_out
- alu_in  input  DATA_WIDTH  processor alu_result
- clr_ovf  input  1  clears overflow flag and drop counter
- rd_ready  input  1  consumer accepts head entry
- rd_valid  output  1  FIFO non-empty
- rd_pc  output  PC_WIDTH  head entry PC
- rd_alu  output  DATA_WIDTH  head entry ALU result
- rd_ts  output  TS_WIDTH  head entry timestamp
- level  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: an entry was dropped
- drop_cnt  output  CNT_WIDTH  saturating count of dropped entries

Behaviour:
- Reset (async, rst_n=0):
  - rd_valid=0, level=0, overflow=0, drop_cnt=0, timestamp=0.
  - rd_pc/rd_alu/rd_ts=0.
  - pc_q=0, armed=0.
  - Reset mid-stream discards all FIFO contents immediately.
- Timestamp: TS_WIDTH counter increments every cycle after reset release; wraps from all-ones to 0.
- Capture request (cap) is asserted in a cycle when trace_en=1 and either armed=0 or pc_in!=pc_q.
  - Entry = {timestamp (current value, pre-increment), pc_in, alu_in}.
  - pc_q<=pc_in every cycle trace_en=1.
  - armed<=trace_en; deasserting trace_en disarms, so the first enabled cycle after re-enable always captures.
- Read: show-ahead FIFO. rd_* present the head combinationally from storage and are 0 when empty. Pop occurs when rd_valid&rd_ready.
- Push/pop rules, per cycle:
  - empty, cap: push; rd_valid=1 next cycle (1-cycle capture-to-valid latency).
  - empty, rd_ready only: no effect.
  - not full, cap and pop: both occur; level unchanged.
  - full, cap and pop: both occur (pop frees the slot in the same cycle); no drop.
  - full, cap, no pop: entry dropped; overflow<=1; drop_cnt increments, saturating at all-ones.
- Pointers: wr/rd pointers $clog2(DEPTH) bits wrap naturally; level tracked separately.
- clr_ovf: overflow<=0 and drop_cnt<=0. If a drop happens in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- No internal FSM beyond armed/FIFO state; no combinational path from rd_ready to rd_valid.

Decomposition:
- Package mips_trace_pkg:
  - trace_entry_t packed struct {ts, pc, alu}, parameterized widths via default localparams matching the processor defaults.
  - TRACE_DEPTH default constant.
- Sub-module mips_trace_fifo:
  - Generic synchronous show-ahead FIFO of trace_entry_t.
  - Ports: push, pop, full, empty, level, head.
- The top holds the timestamp, change detection and overflow logic.

Test Plan:
- Reset then trace_en=1, pc_in 0->2->4 on successive cycles, rd_ready=1:
  - entries (ts,pc) = (1,0),(2,2),(3,4) appear in order, one cycle after each capture.
- pc_in held at 6 for 5 cycles with trace_en=1: exactly one entry, pc=6; toggle trace_en 1->0->1: one new pc=6 entry.
- rd_ready=0, DEPTH=8, 10 distinct PCs:
  - level=8, overflow=1, drop_cnt=2.
  - draining returns the first 8 PCs in order.
- Full FIFO with cap and rd_ready=1 in the same cycle: level stays 8, overflow stays 0, new entry is last out.
- Force 300 drops with CNT_WIDTH=8: drop_cnt=255; clr_ovf alone -> overflow=0, drop_cnt=0; clr_ovf coincident with a drop -> drop_cnt=1, overflow=1.
- Assert rst_n=0 with level=5 mid-drain: rd_valid=0 and level=0 immediately (asynchronous); after release the timestamp restarts at 0.

Source files
------------

// File: rtl/mips_trace_capture_pkg.sv
// Shared types for the MIPS trace capture block: the trace entry layout and
// the default widths and depth that match the processor's pc_out/alu_result.
package mips_trace_pkg;

  localparam int TRACE_PC_W   = 16;
  localparam int TRACE_DATA_W = 16;
  localparam int TRACE_TS_W   = 16;
  localparam int TRACE_CNT_W  = 8;
  localparam int TRACE_DEPTH  = 8;

  typedef struct packed {
    logic [TRACE_TS_W-1:0]   ts;
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_DATA_W-1:0] alu;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_capture_if.sv
// Observation inputs plus the valid/ready trace read port and status of the
// trace capture block; master is the capture block, slave is the consumer.
interface mips_trace_capture_if
  import mips_trace_pkg::*;
#(
  parameter int PC_WIDTH   = TRACE_PC_W,
  parameter int DATA_WIDTH = TRACE_DATA_W,
  parameter int TS_WIDTH   = TRACE_TS_W,
  parameter int DEPTH      = TRACE_DEPTH,
  parameter int CNT_WIDTH  = TRACE_CNT_W
);
  logic                     trace_en;
  logic [PC_WIDTH-1:0]      pc_in;
  logic [DATA_WIDTH-1:0]    alu_in;
  logic                     clr_ovf;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [PC_WIDTH-1:0]      rd_pc;
  logic [DATA_WIDTH-1:0]    rd_alu;
  logic [TS_WIDTH-1:0]      rd_ts;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic [CNT_WIDTH-1:0]     drop_cnt;

  modport master (
    input  trace_en, pc_in, alu_in, clr_ovf, rd_ready,
    output rd_valid, rd_pc, rd_alu, rd_ts, level, overflow, drop_cnt
  );

  modport slave (
    output trace_en, pc_in, alu_in, clr_ovf, rd_ready,
    input  rd_valid, rd_pc, rd_alu, rd_ts, level, overflow, drop_cnt
  );

endinterface

// File: rtl/mips_trace_capture_fifo.sv
// Show-ahead synchronous FIFO: head is valid the cycle after the first push and
// reads as zero when empty; a push into a full FIFO is accepted only alongside a pop.
module mips_trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int  DEPTH   = TRACE_DEPTH,
  parameter type entry_t = trace_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mips_trace_capture.sv
// Passive PC-change tracer: time-stamps each new retired PC into a show-ahead FIFO
// (1-cycle capture-to-valid); when full with no pop the new entry is dropped and counted.
module mips_trace_capture
  import mips_trace_pkg::*;
#(
  parameter int PC_WIDTH   = TRACE_PC_W,
  parameter int DATA_WIDTH = TRACE_DATA_W,
  parameter int TS_WIDTH   = TRACE_TS_W,
  parameter int DEPTH      = TRACE_DEPTH,
  parameter int CNT_WIDTH  = TRACE_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  mips_trace_capture_if.master bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] alu;
  } entry_t;

  logic [TS_WIDTH-1:0]  ts;
  logic [PC_WIDTH-1:0]  pc_q;
  logic                 armed;
  logic                 cap;
  logic                 pop;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [LVL_W-1:0]     level;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_cnt;
  entry_t               wr_entry;
  entry_t               head;

  // A disarmed tracer always captures, so re-enabling records the current PC.
  assign cap      = bus.trace_en & (~armed | (bus.pc_in != pc_q));
  assign pop      = ~empty & bus.rd_ready;
  assign drop     = cap & full & ~pop;
  assign wr_entry = '{ts: ts, pc: bus.pc_in, alu: bus.alu_in};

  mips_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap),
    .pop   (pop),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts    <= '0;
      pc_q  <= '0;
      armed <= 1'b0;
    end else begin
      ts    <= ts + TS_WIDTH'(1);
      armed <= bus.trace_en;
      if (bus.trace_en) begin
        pc_q <= bus.pc_in;
      end
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (bus.clr_ovf) begin
        drop_cnt <= CNT_WIDTH'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end else if (bus.clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign bus.rd_valid = ~empty;
  assign bus.rd_pc    = head.pc;
  assign bus.rd_alu   = head.alu;
  assign bus.rd_ts    = head.ts;
  assign bus.level    = level;
  assign bus.overflow = overflow;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed and random stimulus for mips_trace_capture, checked against a queue-based trace model.
module tb_mips_trace_capture;
  import mips_trace_pkg::*;

  localparam int DEPTH = 8;

  typedef struct {
    int ts;
    int pc;
    int alu;
  } ment_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  ment_t mq[$];
  int    m_ts, m_pcq, m_armed, m_ovf, m_cnt;

  always #5 clk = ~clk;

  mips_trace_capture_if bus ();

  mips_trace_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    ment_t e;
    e = '{0, 0, 0};
    if (mq.size() > 0) e = mq[0];
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(mq.size() > 0));
    check({tag, ".level"},    32'(bus.level),    32'(mq.size()));
    check({tag, ".rd_pc"},    32'(bus.rd_pc),    32'(e.pc));
    check({tag, ".rd_alu"},   32'(bus.rd_alu),   32'(e.alu));
    check({tag, ".rd_ts"},    32'(bus.rd_ts),    32'(e.ts));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_pcq = 0; m_armed = 0; m_ovf = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model by that cycle, then compare after the edge.
  task automatic step(input string tag, input bit en, input int pc, input int alu,
                      input bit clr, input bit rdy);
    bit cap;
    bus.trace_en = en;
    bus.pc_in    = pc[15:0];
    bus.alu_in   = alu[15:0];
    bus.clr_ovf  = clr;
    bus.rd_ready = rdy;
    cap = en && (m_armed == 0 || pc != m_pcq);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    if (cap) begin
      if (mq.size() < DEPTH) begin
        mq.push_back('{m_ts, pc, alu});
      end else begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (en) m_pcq = pc;
    m_armed = en;
    m_ts = (m_ts + 1) % 65536;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) step(tag, 0, 0, 0, 0, 1);
    check({tag, ".empty"}, 32'(bus.rd_valid), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    bus.trace_en = 1'b0;
    bus.pc_in    = '0;
    bus.alu_in   = '0;
    bus.clr_ovf  = 1'b0;
    bus.rd_ready = 1'b0;
    do_reset();

    // First captures after reset: pc 0, 2, 4 streamed with rd_ready high.
    step("idle", 0, 0, 0, 0, 1);
    step("seq_pc0", 1, 0, 16'h1111, 0, 1);
    check("first_ts", 32'(bus.rd_ts), 32'(1));
    step("seq_pc2", 1, 2, 16'h2222, 0, 1);
    check("second_ts", 32'(bus.rd_ts), 32'(2));
    step("seq_pc4", 1, 4, 16'h3333, 0, 1);
    check("third_pc", 32'(bus.rd_pc), 32'(4));
    drain("drain1");

    // Held PC captures once; a trace_en toggle re-arms and captures again.
    for (int i = 0; i < 5; i++) step("hold6", 1, 6, 16'h0600 + i, 0, 0);
    check("hold6_level", 32'(bus.level), 32'(1));
    step("dis", 0, 6, 0, 0, 0);
    step("reen", 1, 6, 16'h0666, 0, 0);
    check("reen_level", 32'(bus.level), 32'(2));
    drain("drain2");

    // Ten distinct PCs into an unread FIFO: two drops, first eight kept in order.
    for (int i = 0; i < 10; i++) step("fill10", 1, 16'h0100 + 2 * i, 16'hA000 + i, 0, 0);
    check("fill10_level", 32'(bus.level), 32'(8));
    check("fill10_ovf", 32'(bus.overflow), 32'(1));
    check("fill10_drops", 32'(bus.drop_cnt), 32'(2));
    check("fill10_head", 32'(bus.rd_pc), 32'(16'h0100));
    drain("drain3");
    step("clr1", 0, 0, 0, 1, 0);

    // Full FIFO with capture and pop together: no drop, new entry last out.
    for (int i = 0; i < 8; i++) step("fill8", 1, 16'h0200 + 2 * i, 16'hB000 + i, 0, 0);
    step("full_cap_pop", 1, 16'h0300, 16'hBEEF, 0, 1);
    check("fcp_level", 32'(bus.level), 32'(8));
    check("fcp_ovf", 32'(bus.overflow), 32'(0));
    drain("drain4");

    // Saturating drop counter and clear behaviour.
    for (int i = 0; i < 8; i++) step("fill8b", 1, 16'h0400 + 2 * i, i, 0, 0);
    for (int i = 0; i < 300; i++) step("drops", 1, 16'h2000 + 2 * i, i, 0, 0);
    check("sat_cnt", 32'(bus.drop_cnt), 32'(255));
    step("clr_only", 1, 16'h2000 + 2 * 299, 0, 1, 0);
    check("clr_cnt", 32'(bus.drop_cnt), 32'(0));
    check("clr_ovf", 32'(bus.overflow), 32'(0));
    step("clr_drop", 1, 16'h3000, 0, 1, 0);
    check("clr_drop_cnt", 32'(bus.drop_cnt), 32'(1));
    check("clr_drop_ovf", 32'(bus.overflow), 32'(1));
    drain("drain5");

    // Random traffic with frequent PC repeats, stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 9) != 0, 2 * $urandom_range(0, 3),
           $urandom_range(0, 65535), $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
    end
    drain("drain6");

    // Asynchronous reset with five entries queued, then timestamp restarts at zero.
    for (int i = 0; i < 5; i++) step("fill5", 1, 16'h0500 + 2 * i, i, 0, 0);
    check("fill5_level", 32'(bus.level), 32'(5));
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.rd_valid), 32'(0));
    check("arst_level", 32'(bus.level), 32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("arst_hold");
    rst_n = 1'b1;
    step("post_rst", 1, 16'h0040, 16'h4444, 0, 0);
    check("post_rst_ts", 32'(bus.rd_ts), 32'(0));
    step("post_rst2", 1, 16'h0042, 16'h4445, 0, 1);
    check("post_rst2_ts", 32'(bus.rd_ts), 32'(1));
    drain("drain7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
